// File: rtl/csm_pkg.sv
// Shared definitions for the shared-memory port controllers.
package csm_pkg;

    localparam int DEF_DATABITS = 8;
    localparam int DEF_ERRBITS  = 2;
    localparam int DEF_TIMEOUT  = 15;

    typedef enum logic [1:0] {
        ERR_OK          = 2'b00,
        ERR_LOCKED      = 2'b01,
        ERR_BAD_RELEASE = 2'b10,
        ERR_TIMEOUT     = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_DATA = 3'd1,
        W_MEM  = 3'd2,
        R_MEM  = 3'd3,
        R_WAIT = 3'd4,
        RESP   = 3'd5
    } port_state_t;

endpackage

// File: rtl/csm_timeout_ctr.sv
// Memory-wait watchdog: counts cycles spent waiting on the arbiter.
module csm_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    // The final wait cycle is the one whose closing edge brings the count to TIMEOUT.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;

    // Clear on entry to a memory wait, advance once per waiting cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_expired = i_enable && (r_cnt == LAST);

endmodule

// File: rtl/csm_port_ctrl.sv
// Processor-side port controller for the shared memory and its lock.
//
// state  | meaning
// IDLE   | ready, ack=1, command decoded when enable=1
// W_DATA | write address held, capturing write data
// W_MEM  | write request to arbiter, waiting for grant
// R_MEM  | read request to arbiter, waiting for grant
// R_WAIT | read granted, waiting for read data
// RESP   | one-cycle completion, ack=1, err valid
module csm_port_ctrl
    import csm_pkg::*;
#(
    parameter int DATABITS = DEF_DATABITS,
    parameter int ERRBITS  = DEF_ERRBITS,
    parameter int TIMEOUT  = DEF_TIMEOUT
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATABITS-1:0] in_AD,
    input  logic                rw,
    input  logic                enable,
    input  logic                hold,
    input  logic                release_req,
    output logic                ack,
    output logic [ERRBITS-1:0]  err,
    output logic [DATABITS-1:0] out_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATABITS-1:0] mem_addr,
    output logic [DATABITS-1:0] mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATABITS-1:0] mem_rdata,
    output logic                lock_req,
    output logic                lock_rel,
    input  logic                lock_other
);

    port_state_t         r_state;
    port_state_t         w_next;
    logic                r_owner;
    logic [ERRBITS-1:0]  r_err;
    logic [DATABITS-1:0] r_out_data;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [DATABITS-1:0] r_mem_addr;
    logic [DATABITS-1:0] r_mem_wdata;
    logic                r_lock_req;
    logic                r_lock_rel;

    logic                w_err_load;
    err_t                w_err_val;
    logic                w_lock_req;
    logic                w_lock_rel;
    logic                w_rdata_load;
    logic                w_tmo_clr;
    logic                w_tmo_en;
    logic                w_expired;

    assign w_tmo_en  = (r_state == W_MEM) || (r_state == R_MEM) || (r_state == R_WAIT);
    assign w_tmo_clr = ((w_next == W_MEM) && (r_state != W_MEM)) ||
                       ((w_next == R_MEM) && (r_state != R_MEM));

    csm_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_clear   (w_tmo_clr),
        .i_enable  (w_tmo_en),
        .o_expired (w_expired)
    );

    // Next-state and completion decode; timeout outranks a same-cycle grant or rvalid.
    always_comb begin
        w_next       = r_state;
        w_err_load   = 1'b0;
        w_err_val    = ERR_OK;
        w_lock_req   = 1'b0;
        w_lock_rel   = 1'b0;
        w_rdata_load = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) begin
                    if (hold) begin
                        w_next     = RESP;
                        w_err_load = 1'b1;
                        if (lock_other) w_err_val  = ERR_LOCKED;
                        else            w_lock_req = 1'b1;
                    end else if (release_req) begin
                        w_next     = RESP;
                        w_err_load = 1'b1;
                        if (r_owner) w_lock_rel = 1'b1;
                        else         w_err_val  = ERR_BAD_RELEASE;
                    end else if (lock_other && !r_owner) begin
                        w_next     = RESP;
                        w_err_load = 1'b1;
                        w_err_val  = ERR_LOCKED;
                    end else begin
                        w_next = rw ? W_DATA : R_MEM;
                    end
                end
            end
            W_DATA: w_next = W_MEM;
            W_MEM: begin
                if (w_expired) begin
                    w_next     = RESP;
                    w_err_load = 1'b1;
                    w_err_val  = ERR_TIMEOUT;
                end else if (mem_gnt) begin
                    w_next     = RESP;
                    w_err_load = 1'b1;
                end
            end
            R_MEM: begin
                if (w_expired) begin
                    w_next     = RESP;
                    w_err_load = 1'b1;
                    w_err_val  = ERR_TIMEOUT;
                end else if (mem_gnt) begin
                    w_next = R_WAIT;
                end
            end
            R_WAIT: begin
                if (w_expired) begin
                    w_next     = RESP;
                    w_err_load = 1'b1;
                    w_err_val  = ERR_TIMEOUT;
                end else if (mem_rvalid) begin
                    w_next       = RESP;
                    w_err_load   = 1'b1;
                    w_rdata_load = 1'b1;
                end
            end
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // State, lock ownership and registered outputs; arbiter strobes follow the next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_owner     <= 1'b0;
            r_err       <= '0;
            r_out_data  <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_lock_req  <= 1'b0;
            r_lock_rel  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_mem_req  <= (w_next == W_MEM) || (w_next == R_MEM);
            r_mem_we   <= (w_next == W_MEM);
            r_lock_req <= w_lock_req;
            r_lock_rel <= w_lock_rel;
            if (w_lock_req) r_owner <= 1'b1;
            else if (w_lock_rel) r_owner <= 1'b0;
            if (w_err_load) r_err <= ERRBITS'(w_err_val);
            if (w_rdata_load) r_out_data <= mem_rdata;
            if ((r_state == IDLE) && ((w_next == W_DATA) || (w_next == R_MEM)))
                r_mem_addr <= in_AD;
            if (r_state == W_DATA) r_mem_wdata <= in_AD;
        end
    end

    assign ack       = (r_state == IDLE) || (r_state == RESP);
    assign err       = r_err;
    assign out_data  = r_out_data;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign lock_req  = r_lock_req;
    assign lock_rel  = r_lock_rel;

endmodule

// File: tb/tb_csm_port_ctrl.sv
// Bench for csm_port_ctrl: directed table, reset-in-flight sequence, random transactions.
module tb_csm_port_ctrl;

    localparam int TMO  = 15;
    localparam int K_WR = 0, K_RD = 1, K_HOLD = 2, K_REL = 3;

    typedef struct {
        int         kind;
        logic       lo;
        logic [7:0] addr;
        logic [7:0] wdata;
        logic [7:0] rdata;
        int         g;       // mem_req cycle index (0-based) on which grant is given
        int         r;       // R_WAIT cycle index (0-based) on which rvalid is given
        int         e_err;
        int         e_busy;  // cycles with ack=0
        int         e_req;   // cycles with mem_req=1
        int         e_lreq;
        int         e_lrel;
        logic [7:0] e_out;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] in_AD;
    logic       rw, enable, hold, release_req;
    logic       ack;
    logic [1:0] err;
    logic [7:0] out_data;
    logic       mem_req, mem_we;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_gnt, mem_rvalid;
    logic [7:0] mem_rdata;
    logic       lock_req, lock_rel, lock_other;

    int checks = 0;
    int errors = 0;
    bit         m_owner;
    logic [7:0] m_out;

    always #5 clk = ~clk;

    csm_port_ctrl dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_AD       (in_AD),
        .rw          (rw),
        .enable      (enable),
        .hold        (hold),
        .release_req (release_req),
        .ack         (ack),
        .err         (err),
        .out_data    (out_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .lock_req    (lock_req),
        .lock_rel    (lock_rel),
        .lock_other  (lock_other)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int kind, input logic lo, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [7:0] rdata,
                                input int g, input int r, input int e_err, input int e_busy,
                                input int e_req, input int e_lreq, input int e_lrel,
                                input logic [7:0] e_out);
        vec_t v;
        v.kind = kind; v.lo = lo; v.addr = addr; v.wdata = wdata; v.rdata = rdata;
        v.g = g; v.r = r; v.e_err = e_err; v.e_busy = e_busy; v.e_req = e_req;
        v.e_lreq = e_lreq; v.e_lrel = e_lrel; v.e_out = e_out;
        return v;
    endfunction

    // Transaction-level reference: outcome follows from lock state and when memory answers.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        int   done_at;
        e.e_lreq = 0; e.e_lrel = 0; e.e_busy = 0; e.e_req = 0; e.e_err = 0;
        if (v.kind == K_HOLD) begin
            if (v.lo) e.e_err = 1;
            else begin e.e_lreq = 1; m_owner = 1'b1; end
        end else if (v.kind == K_REL) begin
            if (m_owner) begin e.e_lrel = 1; m_owner = 1'b0; end
            else e.e_err = 2;
        end else if (v.lo && !m_owner) begin
            e.e_err = 1;
        end else begin
            done_at  = (v.kind == K_WR) ? v.g : v.g + 1 + v.r;
            e.e_req  = (v.g + 1 < TMO) ? v.g + 1 : TMO;
            e.e_busy = ((done_at + 1 < TMO) ? done_at + 1 : TMO) + ((v.kind == K_WR) ? 1 : 0);
            if (done_at < TMO - 1) begin
                if (v.kind == K_RD) m_out = v.rdata;
            end else begin
                e.e_err = 3;
            end
        end
        e.e_out = m_out;
        return e;
    endfunction

    // Called at a negedge with the DUT in IDLE; returns at the following IDLE negedge.
    task automatic run_txn(input vec_t v, input bit spur, input string tag);
        int busy = 0, reqc = 0, ridx = 0, bad = 0, lreqc = 0, lrelc = 0;
        bit rwait = 0, done = 0;
        enable = 1'b1; hold = (v.kind == K_HOLD); release_req = (v.kind == K_REL);
        rw = (v.kind == K_WR); in_AD = v.addr; lock_other = v.lo;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            lreqc += int'(lock_req);
            lrelc += int'(lock_rel);
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 8'($urandom);
            enable = 1'($urandom); hold = 1'($urandom);
            release_req = 1'($urandom); rw = 1'($urandom);
            in_AD = (c == 0) ? v.wdata : 8'($urandom);
            if (ack) begin
                done = 1;
            end else begin
                busy++;
                if (mem_req) begin
                    if (mem_we !== (v.kind == K_WR) || mem_addr !== v.addr ||
                        (v.kind == K_WR && mem_wdata !== v.wdata)) bad++;
                    if (reqc == v.g) begin
                        mem_gnt = 1'b1;
                        rwait = (v.kind == K_RD);
                    end else if (spur) begin
                        mem_rvalid = 1'($urandom);
                    end
                    reqc++;
                end else if (rwait) begin
                    if (ridx == v.r) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = v.rdata;
                    end
                    ridx++;
                end else if (spur) begin
                    mem_rvalid = 1'($urandom);
                end
            end
        end
        chk({tag, "_reached_resp"}, int'(done), 1);
        chk({tag, "_err"}, int'(err), v.e_err);
        chk({tag, "_out_data"}, int'(out_data), int'(v.e_out));
        chk({tag, "_resp_lock_req"}, int'(lock_req), v.e_lreq);
        chk({tag, "_resp_lock_rel"}, int'(lock_rel), v.e_lrel);
        chk({tag, "_resp_mem_req"}, int'(mem_req), 0);
        chk({tag, "_busy_cycles"}, busy, v.e_busy);
        chk({tag, "_req_cycles"}, reqc, v.e_req);
        chk({tag, "_req_fields_bad"}, bad, 0);
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        @(negedge clk);
        lreqc += int'(lock_req);
        lrelc += int'(lock_rel);
        enable = 1'b0; hold = 1'b0; release_req = 1'b0;
        chk({tag, "_idle_ack"}, int'(ack), 1);
        chk({tag, "_err_held"}, int'(err), v.e_err);
        chk({tag, "_lock_req_pulses"}, lreqc, v.e_lreq);
        chk({tag, "_lock_rel_pulses"}, lrelc, v.e_lrel);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ack"}, int'(ack), 1);
        chk({tag, "_err"}, int'(err), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
        chk({tag, "_mem_req"}, int'(mem_req), 0);
        chk({tag, "_mem_we"}, int'(mem_we), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_mem_wdata"}, int'(mem_wdata), 0);
        chk({tag, "_lock_req"}, int'(lock_req), 0);
        chk({tag, "_lock_rel"}, int'(lock_rel), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[16];
        vec_t v;
        tbl[0]  = mk(K_WR,   0, 8'h3C, 8'hA5, 8'h00,  2,  0, 0,  4,  3, 0, 0, 8'h00);
        tbl[1]  = mk(K_RD,   0, 8'h3C, 8'h00, 8'hA5,  1,  3, 0,  6,  2, 0, 0, 8'hA5);
        tbl[2]  = mk(K_REL,  0, 8'h00, 8'h00, 8'h00,  0,  0, 2,  0,  0, 0, 0, 8'hA5);
        tbl[3]  = mk(K_HOLD, 1, 8'h00, 8'h00, 8'h00,  0,  0, 1,  0,  0, 0, 0, 8'hA5);
        tbl[4]  = mk(K_HOLD, 0, 8'h00, 8'h00, 8'h00,  0,  0, 0,  0,  0, 1, 0, 8'hA5);
        tbl[5]  = mk(K_RD,   1, 8'h55, 8'h00, 8'h77,  0,  0, 0,  2,  1, 0, 0, 8'h77);
        tbl[6]  = mk(K_WR,   1, 8'h10, 8'h20, 8'h00,  0,  0, 0,  2,  1, 0, 0, 8'h77);
        tbl[7]  = mk(K_REL,  0, 8'h00, 8'h00, 8'h00,  0,  0, 0,  0,  0, 0, 1, 8'h77);
        tbl[8]  = mk(K_RD,   1, 8'h66, 8'h00, 8'h99,  0,  0, 1,  0,  0, 0, 0, 8'h77);
        tbl[9]  = mk(K_WR,   1, 8'h67, 8'h01, 8'h00,  0,  0, 1,  0,  0, 0, 0, 8'h77);
        tbl[10] = mk(K_RD,   0, 8'h44, 8'h00, 8'hEE, 20,  0, 3, 15, 15, 0, 0, 8'h77);
        tbl[11] = mk(K_WR,   0, 8'h45, 8'h5A, 8'h00, 13,  0, 0, 15, 14, 0, 0, 8'h77);
        tbl[12] = mk(K_WR,   0, 8'h46, 8'h5B, 8'h00, 14,  0, 3, 16, 15, 0, 0, 8'h77);
        tbl[13] = mk(K_RD,   0, 8'h47, 8'h00, 8'h11,  0, 13, 3, 15,  1, 0, 0, 8'h77);
        tbl[14] = mk(K_RD,   0, 8'h48, 8'h00, 8'hC3,  0, 12, 0, 14,  1, 0, 0, 8'hC3);
        tbl[15] = mk(K_RD,   0, 8'h49, 8'h00, 8'h22, 13,  0, 3, 15, 14, 0, 0, 8'hC3);

        reset_n = 1'b0; in_AD = '0; rw = 0; enable = 0; hold = 0; release_req = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; lock_other = 0;
        m_owner = 1'b0; m_out = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        // Command presented together with reset release must be taken on the first edge.
        reset_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = model(tbl[i]);
            run_txn(tbl[i], 1'b1, $sformatf("tbl%0d", i));
        end

        // Own the lock and leave a non-zero err, then reset in the middle of a read.
        run_txn(model(mk(K_HOLD, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), 1'b0, "pre_hold");
        run_txn(model(mk(K_HOLD, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)), 1'b0, "pre_locked");
        enable = 1'b1; hold = 1'b0; release_req = 1'b0; rw = 1'b0; in_AD = 8'h42; lock_other = 1'b0;
        @(negedge clk);
        enable = 1'b0;
        chk("rst_rmem_req", int'(mem_req), 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("rst_rwait_ack", int'(ack), 0);
        chk("rst_rwait_req", int'(mem_req), 0);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        chk("rst_no_lock_rel", int'(lock_rel), 0);
        reset_n = 1'b1;
        m_owner = 1'b0; m_out = '0;
        run_txn(model(mk(K_WR, 0, 8'h3C, 8'hA5, 0, 2, 0, 0, 0, 0, 0, 0, 0)), 1'b1, "post_wr");
        run_txn(model(mk(K_RD, 1, 8'h3C, 0, 8'h5E, 0, 0, 0, 0, 0, 0, 0, 0)), 1'b1, "post_owner_cleared");

        for (int i = 0; i < 40; i++) begin
            int k = $urandom_range(0, 5);
            v.kind  = (k < 2) ? K_WR : (k < 4) ? K_RD : (k == 4) ? K_HOLD : K_REL;
            v.lo    = ($urandom_range(0, 3) == 0);
            v.addr  = 8'($urandom);
            v.wdata = 8'($urandom);
            v.rdata = 8'($urandom);
            v.g     = $urandom_range(0, 16);
            v.r     = $urandom_range(0, 14);
            run_txn(model(v), 1'($urandom), $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
